add_pair_driver: RTL and testbench



---
 rtl/add_pair_pkg.sv | 15 +
 rtl/add_pair_driver.sv | 112 +++++++++++
 tb/tb_add_pair_driver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_pair_pkg.sv
// Shared types for the adder-pair initiator: FSM state encoding and the
// adder latency range the wait counter has to cover.
package add_pair_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitB,
        StWait,
        StResp
    } state_e;

    localparam int unsigned LatMax = 15;
    localparam int unsigned LatW   = 4;

endpackage

// File: rtl/add_pair_driver.sv
// Pairs consecutive input beats into adder operands, waits out the adder
// latency, then returns the sum and its unsigned carry-out on a valid/ready output.
module add_pair_driver
    import add_pair_pkg::*;
#(
    parameter int unsigned BIT   = 8,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIT-1:0]   in_data,
    output logic [BIT-1:0]   add_a,
    output logic [BIT-1:0]   add_b,
    input  logic [BIT-1:0]   add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIT-1:0]   out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] pair_cnt
);

    state_e            state_q, state_d;
    logic [BIT-1:0]    add_a_q, add_a_d;
    logic [BIT-1:0]    add_b_q, add_b_d;
    logic [LatW-1:0]   wcnt_q, wcnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BIT-1:0]    out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            add_a_q     <= '0;
            add_b_q     <= '0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            pair_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        pair_cnt_d  = pair_cnt_q;
        in_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    add_a_d = in_data;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    add_b_d = in_data;
                    wcnt_d  = LatW'(LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - LatW'(1);
                end else begin
                    out_data_d  = add_sum;
                    // A wrapped sum is smaller than either operand exactly on carry-out.
                    out_ovf_d   = (add_sum < add_a_q);
                    out_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pair_cnt_d  = pair_cnt_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_add_pair_driver.sv
// Bench for add_pair_driver: a LAT=1/CNT_W=16 instance and a LAT=0/CNT_W=2
// instance, each with its own adder, checked against plain 9-bit arithmetic.
module tb_add_pair_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, out_ready;
    logic [7:0] in_data;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [7:0]  add_a0, add_b0, add_sum0, out_data0;
    logic [15:0] pair_cnt0;

    logic        in_ready1, out_valid1, out_ovf1;
    logic [7:0]  add_a1, add_b1, add_sum1, out_data1;
    logic [1:0]  pair_cnt1;

    // Registered adder, one cycle of latency.
    always @(posedge clk) add_sum0 <= add_a0 + add_b0;
    // Zero-latency adder.
    assign add_sum1 = add_a1 + add_b1;

    add_pair_driver #(.BIT(8), .LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .add_a(add_a0), .add_b(add_b0), .add_sum(add_sum0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0), .pair_cnt(pair_cnt0)
    );

    add_pair_driver #(.BIT(8), .LAT(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_ovf(out_ovf1), .pair_cnt(pair_cnt1)
    );

    logic        sel;
    logic        c_ready, c_valid, c_ovf;
    logic [7:0]  c_a, c_b, c_data;
    logic [15:0] c_cnt;

    always_comb begin
        c_ready = sel ? in_ready1  : in_ready0;
        c_valid = sel ? out_valid1 : out_valid0;
        c_ovf   = sel ? out_ovf1   : out_ovf0;
        c_a     = sel ? add_a1     : add_a0;
        c_b     = sel ? add_b1     : add_b0;
        c_data  = sel ? out_data1  : out_data0;
        c_cnt   = sel ? {14'b0, pair_cnt1} : pair_cnt0;
    end

    int          errs = 0;
    int          checks = 0;
    int          cur_lat;
    logic [15:0] cnt_mask;
    logic [15:0] model_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Presents one beat and holds it until the selected DUT takes it.
    task automatic send_beat(input logic [7:0] d, input int gap);
        logic hs;
        logic done;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        done     = 1'b0;
        for (int i = 0; i < 50; i++) begin
            hs = c_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check_eq("in_handshake", 32'(done), 32'd1);
    endtask

    // Called right after the B handshake; checks latency, result and the stall window.
    task automatic collect(input logic [7:0] a, input logic [7:0] b, input int stall);
        logic [8:0] r;
        int n;
        r = {1'b0, a} + {1'b0, b};
        check_eq("valid_early", 32'(c_valid), 32'd0);
        n = 0;
        while (!c_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", n, cur_lat + 1);
        check_eq("out_data", 32'(c_data), 32'(r[7:0]));
        check_eq("out_ovf", 32'(c_ovf), 32'(r[8]));
        check_eq("add_a_held", 32'(c_a), 32'(a));
        check_eq("add_b_held", 32'(c_b), 32'(b));
        check_eq("in_ready_resp", 32'(c_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid", 32'(c_valid), 32'd1);
            check_eq("stall_data", 32'(c_data), 32'(r[7:0]));
            check_eq("stall_a", 32'(c_a), 32'(a));
            check_eq("stall_b", 32'(c_b), 32'(b));
            check_eq("stall_in_ready", 32'(c_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        model_cnt = (model_cnt + 16'd1) & cnt_mask;
        check_eq("valid_drop", 32'(c_valid), 32'd0);
        check_eq("pair_cnt", 32'(c_cnt), 32'(model_cnt));
        check_eq("in_ready_idle", 32'(c_ready), 32'd1);
    endtask

    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input int gap,
                            input int stall);
        send_beat(a, 0);
        send_beat(b, gap);
        collect(a, b, stall);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        sel       = 1'b0;
        cur_lat   = 1;
        cnt_mask  = 16'hFFFF;
        model_cnt = 16'd0;

        #12;
        check_eq("rst_valid", 32'(c_valid), 32'd0);
        check_eq("rst_data", 32'(c_data), 32'd0);
        check_eq("rst_ovf", 32'(c_ovf), 32'd0);
        check_eq("rst_a", 32'(c_a), 32'd0);
        check_eq("rst_b", 32'(c_b), 32'd0);
        check_eq("rst_cnt", 32'(c_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(c_ready), 32'd1);

        run_pair(8'h12, 8'h34, 0, 0);
        run_pair(8'hF0, 8'h20, 0, 0);
        run_pair(8'hFF, 8'h01, 0, 0);
        run_pair(8'h00, 8'h00, 0, 0);
        run_pair(8'hA5, 8'h5A, 0, 10);

        // Gap between A and B, then in_valid held high through WAIT/RESP.
        send_beat(8'h07, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("gap_in_ready", 32'(c_ready), 32'd1);
            check_eq("gap_a_kept", 32'(c_a), 32'h07);
        end
        send_beat(8'h09, 0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        collect(8'h07, 8'h09, 2);
        check_eq("hold_a_not_taken", 32'(c_a), 32'h07);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("hold_a_taken", 32'(c_a), 32'h33);
        send_beat(8'h44, 0);
        collect(8'h33, 8'h44, 0);

        // Reset while waiting on the adder.
        send_beat(8'h55, 0);
        send_beat(8'h11, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("wrst_valid", 32'(c_valid), 32'd0);
        check_eq("wrst_a", 32'(c_a), 32'd0);
        check_eq("wrst_b", 32'(c_b), 32'd0);
        check_eq("wrst_cnt", 32'(c_cnt), 32'd0);
        check_eq("wrst_data", 32'(c_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 16'd0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_eq("wrst_no_valid", 32'(c_valid), 32'd0);
        end
        run_pair(8'h01, 8'h02, 0, 0);

        for (int i = 0; i < 20; i++) begin
            run_pair(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
        end

        // Zero-latency, 2-bit counter instance.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        sel       = 1'b1;
        cur_lat   = 0;
        cnt_mask  = 16'h0003;
        model_cnt = 16'd0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            run_pair(8'($urandom), 8'($urandom), 0, int'($urandom_range(0, 2)));
        end
        run_pair(8'hFF, 8'hFF, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
